spi_memory: RTL and testbench

SPI-slave-addressed 128×8 register memory. Bit-serial commands arrive on an SPI link sampled by a fast system clock. A 7-bit address plus R/W bit either stores a byte shifted in on MOSI or returns a stored byte on a tri-stated MISO. Sits at the board edge between an external SPI master and on-chip storage; a 4-bit LED debug output reflects activity.

---
 rtl/spi_memory_if.sv | 12 +
 rtl/spi_memory.sv | 102 ++++++++++
 tb/tb_spi_memory.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/spi_memory_if.sv
// spi_memory_if: SPI pin bundle between an external master and the memory slave
interface spi_memory_if;
  logic sclk_pin;
  logic cs_pin;
  logic mosi_pin;
  logic miso_pin;
  // miso_oe is the pad output enable, so on-chip logic can see when MISO floats
  logic miso_oe;
  logic [3:0] leds;
  modport master(output sclk_pin, cs_pin, mosi_pin, input miso_pin, miso_oe, leds);
  modport slave(input sclk_pin, cs_pin, mosi_pin, output miso_pin, miso_oe, leds);
endinterface

// File: rtl/spi_memory.sv
// spi_memory: SPI-slave 128x8 register memory; define SPI_INPUT_FILTER_EN for 3-sample input glitch filters
module spi_memory (
  input  logic        clk,
  input  logic        reset_n,
  spi_memory_if.slave bus
);
  typedef enum logic [2:0] {GET_CMD, WRITE_GET, WRITE_STORE, READ_LOAD, READ_SEND, DONE} state_t;
  localparam logic [2:0] IDLE = 3'b010;
  state_t state, state_nx;
  logic [2:0] sync1, sync2, in_f;
  logic sclk_d, sclk_rise, sclk_fall, cs_high, mosi;
  logic [3:0] cnt;
  logic [7:0] shreg, tx;
  logic [6:0] addr;
  logic miso_q, miso_oe;
  logic [3:0] leds;
  logic [7:0] mem [128];
  // two-flop synchronizer for {sclk, cs, mosi}; reset to the idle bus levels
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {sync2, sync1} <= {IDLE, IDLE};
    else {sync2, sync1} <= {sync1, {bus.sclk_pin, bus.cs_pin, bus.mosi_pin}};
`ifdef SPI_INPUT_FILTER_EN
  logic [2:0][1:0] flt_cnt;
  // accept a new level only after three consecutive differing samples
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      in_f <= IDLE;
      flt_cnt <= '0;
    end else
      for (int i = 0; i < 3; i++)
        if (sync2[i] == in_f[i]) flt_cnt[i] <= 2'd0;
        else if (flt_cnt[i] == 2'd2) begin
          in_f[i] <= sync2[i];
          flt_cnt[i] <= 2'd0;
        end else flt_cnt[i] <= flt_cnt[i] + 2'd1;
`else
  assign in_f = sync2;
`endif
  // delayed sclk for one-clk edge pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sclk_d <= 1'b0;
    else sclk_d <= in_f[2];
  assign sclk_rise = in_f[2] & ~sclk_d;
  assign sclk_fall = ~in_f[2] & sclk_d;
  assign cs_high = in_f[1];
  assign mosi = in_f[0];
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= GET_CMD;
    else state <= state_nx;
  // next state; a deselected chip always returns to command decode
  always_comb begin
    state_nx = state;
    if (cs_high) state_nx = GET_CMD;
    else
      case (state)
        GET_CMD:     if (sclk_rise && cnt == 4'd7) state_nx = mosi ? READ_LOAD : WRITE_GET;
        WRITE_GET:   if (sclk_rise && cnt == 4'd7) state_nx = WRITE_STORE;
        WRITE_STORE: state_nx = DONE;
        READ_LOAD:   state_nx = READ_SEND;
        READ_SEND:   if (sclk_fall && cnt == 4'd8) state_nx = DONE;
        default:     state_nx = state;
      endcase
  end
  // MISO is driven only while sending read data with CS low
  always_comb miso_oe = state == READ_SEND && !cs_high;
  assign bus.miso_oe = miso_oe;
  assign bus.miso_pin = miso_oe ? miso_q : 1'bz;
  assign bus.leds = leds;
  // datapath: command/data shifting, read serializer, debug leds
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      shreg <= '0;
      tx <= '0;
      addr <= '0;
      miso_q <= 1'b0;
      leds <= '0;
    end else if (cs_high) cnt <= '0;
    else
      case (state)
        GET_CMD, WRITE_GET: if (sclk_rise) begin
          shreg <= {shreg[6:0], mosi};
          cnt <= cnt == 4'd7 ? 4'd0 : cnt + 4'd1;
          if (state == GET_CMD && cnt == 4'd7) addr <= shreg[6:0];
        end
        WRITE_STORE: leds <= shreg[3:0];
        READ_LOAD: begin
          tx <= mem[addr];
          miso_q <= mem[addr][7];
        end
        READ_SEND: if (sclk_fall && cnt != 4'd8) begin
          miso_q <= tx[7];
          tx <= {tx[6:0], 1'b0};
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
  // storage array, intentionally not reset
  always_ff @(posedge clk)
    if (state == WRITE_STORE && !cs_high) mem[addr] <= shreg;
endmodule

// File: tb/tb_spi_memory.sv
// tb_spi_memory: randomized SPI master driving spi_memory against a byte-array reference model
module tb_spi_memory;
  localparam int H = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0, errors = 0, z_viol = 0;
  logic watch_z = 1'b0;
  logic [7:0] model [128];
  logic [3:0] model_leds = 4'h0;

  spi_memory_if bus();
  spi_memory dut(.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (watch_z && bus.miso_oe) z_viol++;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_cycle(input logic mo, input logic glitch, output logic mi, output logic oe);
    bus.mosi_pin = mo;
    if (glitch) begin
      repeat (3) @(negedge clk);
      bus.sclk_pin = 1'b1;
      @(negedge clk);
      bus.sclk_pin = 1'b0;
      repeat (H - 4) @(negedge clk);
    end else repeat (H) @(negedge clk);
    mi = bus.miso_pin;
    oe = bus.miso_oe;
    bus.sclk_pin = 1'b1;
    repeat (H) @(negedge clk);
    bus.sclk_pin = 1'b0;
  endtask

  task automatic xfer(input logic [6:0] a, input logic rw, input logic [7:0] wd, input int nd,
                      input logic csv, input logic glitch, output logic [7:0] rd, output int oe_n);
    logic [7:0] cmd;
    logic mi, oe;
    cmd = {a, rw};
    rd = '0;
    oe_n = 0;
    bus.cs_pin = csv;
    repeat (H) @(negedge clk);
    for (int i = 7; i >= 0; i--) bit_cycle(cmd[i], 1'b0, mi, oe);
    for (int i = 0; i < nd; i++) begin
      bit_cycle(wd[7-i], glitch, mi, oe);
      rd[7-i] = mi;
      oe_n += int'(oe);
    end
    repeat (H) @(negedge clk);
    bus.cs_pin = 1'b1;
    repeat (H) @(negedge clk);
    if (!rw && nd == 8 && !csv) begin
      model[a] = wd;
      model_leds = wd[3:0];
    end
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input logic glitch);
    logic [7:0] r;
    int n;
    xfer(a, 1'b0, d, 8, 1'b0, glitch, r, n);
    check("wr_leds", 32'(bus.leds), 32'(model_leds));
    check("wr_oe", n, 0);
  endtask

  task automatic do_read(input logic [6:0] a);
    logic [7:0] r;
    int n;
    xfer(a, 1'b1, 8'h00, 8, 1'b0, 1'b0, r, n);
    check($sformatf("rd_%02h", a), 32'(r), 32'(model[a]));
    check("rd_oe_bits", n, 8);
    check("rd_z_after_cs", 32'(bus.miso_oe), 0);
  endtask

  initial begin
    logic [7:0] cmd, r;
    logic mi, oe;
    int n;
    bus.sclk_pin = 1'b0;
    bus.cs_pin = 1'b1;
    bus.mosi_pin = 1'b0;
    #1;
    check("rst_oe", 32'(bus.miso_oe), 0);
    check("rst_leds", 32'(bus.leds), 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (H) @(negedge clk);
    check("idle_oe", 32'(bus.miso_oe), 0);

    do_write(7'h61, 8'hB1, 1'b0);
    do_read(7'h61);
    check("leds_b1", 32'(bus.leds), 4'h1);

    for (int a = 0; a < 128; a++) do_write(7'(a), 8'hB3, 1'b0);
    check("leds_b3", 32'(bus.leds), 4'h3);
    do_read(7'h00);
    do_read(7'h7F);
    for (int k = 0; k < 20; k++) do_read(7'($urandom_range(127)));

    watch_z = 1'b1;
    for (int k = 0; k < 16; k++) begin
      xfer(7'($urandom_range(127)), 1'b0, 8'h82, 8, 1'b1, 1'b0, r, n);
      check("cs_high_oe", n, 0);
    end
    watch_z = 1'b0;
    check("cs_high_z_viol", z_viol, 0);
    check("cs_high_leds", 32'(bus.leds), 32'(model_leds));
    do_read(7'h21);
    do_read(7'h5C);

    xfer(7'h10, 1'b0, 8'h00, 4, 1'b0, 1'b0, r, n);
    do_read(7'h10);
    check("abort_leds", 32'(bus.leds), 32'(model_leds));

    bus.cs_pin = 1'b0;
    repeat (H) @(negedge clk);
    cmd = {7'h05, 1'b1};
    for (int i = 7; i >= 0; i--) bit_cycle(cmd[i], 1'b0, mi, oe);
    for (int i = 0; i < 3; i++) bit_cycle(1'b0, 1'b0, mi, oe);
    check("mid_read_oe", 32'(oe), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_oe", 32'(bus.miso_oe), 0);
    check("mid_rst_leds", 32'(bus.leds), 0);
    model_leds = 4'h0;
    bus.cs_pin = 1'b1;
    bus.sclk_pin = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (H) @(negedge clk);
    do_read(7'h05);

    for (int k = 0; k < 30; k++)
      if ($urandom_range(1) == 1) do_read(7'($urandom_range(127)));
      else do_write(7'($urandom_range(127)), 8'($urandom), 1'b0);

`ifdef SPI_INPUT_FILTER_EN
    do_write(7'h22, 8'h5A, 1'b1);
    do_read(7'h22);
    do_write(7'h23, 8'($urandom), 1'b1);
    do_read(7'h23);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
